bp_cce_mmio_cfg_responder: RTL

BP_CCE_MMIO_CFG_RESPONDER -- requirements
Module: bp_cce_mmio_cfg_responder

---
 rtl/bp_cce_mmio_cfg_responder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_cce_mmio_cfg_responder.sv
// bp_cce_mmio_cfg_responder
//
// Memory-mapped configuration responder for one CCE tile. It accepts one
// command at a time and services the core control registers (reset,
// freeze, cache modes, CCE mode, start PC) and the CCE microcode RAM port.
// Every accepted command receives exactly one response.
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   cce_id_i                       id of this tile, matched against addr.cce
//   io_cmd_i/_v_i/_ready_o         command message, ready-valid
//   io_resp_o/_v_o/_yumi_i         response message, valid-then-yumi
//   reset_o, freeze_o              core reset and freeze controls
//   icache_mode_o, dcache_mode_o   LCE modes
//   cce_mode_o                     CCE mode
//   npc_o, npc_w_v_o               start PC and its one-cycle write pulse
//   ucode_v_o/_w_o/_addr_o/_data_o ucode RAM request, issued in the accept cycle
//   ucode_data_i                   ucode RAM read data, one cycle after request
//
// Message layout (MSB first): msg_type | addr | size | payload | data.
// Config address layout: [15:0] register/ucode address, [21:16] cce,
// [25:22] device; remaining address bits are ignored.
//
// bp_params_p = 0 is the default (inv) configuration; 1 selects a wider
// physical/virtual address map. inst_ram_addr_width_p and inst_width_p
// are normally overridden by the CCE that owns the ucode RAM; the defaults
// are only usable placeholders.
//
// State    | Meaning
// ---------+----------------------------------------------------------
// READY    | idle, io_cmd_ready_o high, command accepted on v & ready
// UCODE_RD | ucode RAM read in flight, capture ucode_data_i this cycle
// RESP     | response held on io_resp_o until io_resp_yumi_i

module bp_cce_mmio_cfg_responder #(
  parameter int bp_params_p           = 0,
  parameter int inst_ram_addr_width_p = 9,
  parameter int inst_width_p          = 32,

  localparam int paddr_width_p        = (bp_params_p == 1) ? 56 : 40,
  localparam int vaddr_width_p        = (bp_params_p == 1) ? 64 : 39,
  localparam int cfg_addr_width_p     = 16,
  localparam int cce_id_width_p       = 6,
  localparam int cfg_dev_width_lp     = 4,
  localparam int dword_width_p        = 64,
  localparam int msg_type_width_lp    = 4,
  localparam int size_width_lp        = 3,
  localparam int payload_width_lp     = 16,
  localparam int cce_mem_msg_width_lp = msg_type_width_lp + paddr_width_p
                                      + size_width_lp + payload_width_lp
                                      + dword_width_p,
  localparam int lce_mode_width_lp    = 2,
  localparam int cce_mode_width_lp    = 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_id_width_p-1:0]       cce_id_i,

  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,

  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,

  output logic                            reset_o,
  output logic                            freeze_o,
  output logic [lce_mode_width_lp-1:0]    icache_mode_o,
  output logic [lce_mode_width_lp-1:0]    dcache_mode_o,
  output logic [cce_mode_width_lp-1:0]    cce_mode_o,
  output logic [vaddr_width_p-1:0]        npc_o,
  output logic                            npc_w_v_o,

  output logic                            ucode_v_o,
  output logic                            ucode_w_o,
  output logic [inst_ram_addr_width_p-1:0] ucode_addr_o,
  output logic [inst_width_p-1:0]         ucode_data_o,
  input  logic [inst_width_p-1:0]         ucode_data_i
);

  localparam logic [msg_type_width_lp-1:0] e_cce_mem_uc_rd = 4'd2;
  localparam logic [msg_type_width_lp-1:0] e_cce_mem_uc_wr = 4'd3;

  localparam logic [cfg_dev_width_lp-1:0] cfg_dev_gp = 4'd2;

  localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_reset_gp       = 16'h0000;
  localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_freeze_gp      = 16'h0008;
  localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_npc_gp         = 16'h0010;
  localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_icache_mode_gp = 16'h0018;
  localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_dcache_mode_gp = 16'h0020;
  localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_cce_mode_gp    = 16'h0028;
  localparam logic [cfg_addr_width_p-1:0] bp_cfg_mem_base_cce_ucode_gp = 16'h8000;

  // Reset values of the mode enums: uncached for both LCE and CCE.
  localparam logic [lce_mode_width_lp-1:0] e_lce_mode_uncached = '0;
  localparam logic [cce_mode_width_lp-1:0] e_cce_mode_uncached = '0;

  typedef struct packed {
    logic [msg_type_width_lp-1:0] msg_type;
    logic [paddr_width_p-1:0]     addr;
    logic [size_width_lp-1:0]     size;
    logic [payload_width_lp-1:0]  payload;
    logic [dword_width_p-1:0]     data;
  } msg_s;

  typedef enum logic [1:0] {READY, UCODE_RD, RESP} state_e;

  state_e                       r_state;
  msg_s                         r_resp;
  logic                         r_reset;
  logic                         r_freeze;
  logic [lce_mode_width_lp-1:0] r_icache_mode;
  logic [lce_mode_width_lp-1:0] r_dcache_mode;
  logic [cce_mode_width_lp-1:0] r_cce_mode;
  logic [vaddr_width_p-1:0]     r_npc;
  logic                         r_npc_w_v;

  msg_s                         w_cmd;
  msg_s                         w_hdr;
  logic [cfg_addr_width_p-1:0]  w_cfg_addr;
  logic [cce_id_width_p-1:0]    w_cmd_cce;
  logic [cfg_dev_width_lp-1:0]  w_cmd_dev;
  logic [cfg_addr_width_p-1:0]  w_ucode_off;
  logic                         w_accept;
  logic                         w_is_local;
  logic                         w_is_uc_rd;
  logic                         w_is_uc_wr;
  logic                         w_is_ucode;
  logic                         w_ucode_hit;
  logic                         w_reg_wr;
  logic [dword_width_p-1:0]     w_reg_rdata;
  logic [dword_width_p-1:0]     w_rd_data;
  logic                         w_unused;

  // Command decode
  assign w_cmd      = io_cmd_i;
  assign w_cfg_addr = w_cmd.addr[cfg_addr_width_p-1:0];
  assign w_cmd_cce  = w_cmd.addr[cfg_addr_width_p +: cce_id_width_p];
  assign w_cmd_dev  = w_cmd.addr[cfg_addr_width_p+cce_id_width_p +: cfg_dev_width_lp];

  assign w_accept   = io_cmd_v_i & io_cmd_ready_o;
  assign w_is_local = (w_cmd_cce == cce_id_i) && (w_cmd_dev == cfg_dev_gp);
  assign w_is_uc_rd = (w_cmd.msg_type == e_cce_mem_uc_rd);
  assign w_is_uc_wr = (w_cmd.msg_type == e_cce_mem_uc_wr);
  assign w_is_ucode = (w_cfg_addr >= bp_cfg_mem_base_cce_ucode_gp);

  // Only uc_rd / uc_wr addressed to this tile's cfg device touch anything;
  // everything else is answered with zero data and no side effect.
  assign w_ucode_hit = w_accept & w_is_local & w_is_ucode & (w_is_uc_rd | w_is_uc_wr);
  assign w_reg_wr    = w_accept & w_is_local & ~w_is_ucode & w_is_uc_wr;
  assign w_ucode_off = w_cfg_addr - bp_cfg_mem_base_cce_ucode_gp;

  always_comb begin
    w_reg_rdata = '0;
    case (w_cfg_addr)
      bp_cfg_reg_reset_gp:       w_reg_rdata = dword_width_p'(r_reset);
      bp_cfg_reg_freeze_gp:      w_reg_rdata = dword_width_p'(r_freeze);
      bp_cfg_reg_npc_gp:         w_reg_rdata = dword_width_p'(r_npc);
      bp_cfg_reg_icache_mode_gp: w_reg_rdata = dword_width_p'(r_icache_mode);
      bp_cfg_reg_dcache_mode_gp: w_reg_rdata = dword_width_p'(r_dcache_mode);
      bp_cfg_reg_cce_mode_gp:    w_reg_rdata = dword_width_p'(r_cce_mode);
      default:                   w_reg_rdata = '0;
    endcase
  end

  assign w_rd_data = (w_is_local & w_is_uc_rd & ~w_is_ucode) ? w_reg_rdata : '0;

  // Response header echoes the command; data is replaced by the read result
  // (ucode reads overwrite it again in UCODE_RD).
  always_comb begin
    w_hdr      = w_cmd;
    w_hdr.data = w_rd_data;
  end

  // The ucode RAM request has to go out in the accept cycle so that a read
  // result is available in UCODE_RD, one cycle later.
  assign ucode_v_o    = w_ucode_hit;
  assign ucode_w_o    = w_ucode_hit & w_is_uc_wr;
  assign ucode_addr_o = w_ucode_off[inst_ram_addr_width_p-1:0];
  assign ucode_data_o = w_cmd.data[inst_width_p-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= READY;
      r_resp        <= '0;
      r_reset       <= 1'b1;
      r_freeze      <= 1'b1;
      r_icache_mode <= e_lce_mode_uncached;
      r_dcache_mode <= e_lce_mode_uncached;
      r_cce_mode    <= e_cce_mode_uncached;
      r_npc         <= '0;
      r_npc_w_v     <= 1'b0;
    end else begin
      r_npc_w_v <= 1'b0;
      case (r_state)
        READY: begin
          if (w_accept) begin
            r_resp  <= w_hdr;
            r_state <= (w_ucode_hit & w_is_uc_rd) ? UCODE_RD : RESP;
            if (w_reg_wr) begin
              case (w_cfg_addr)
                bp_cfg_reg_reset_gp:       r_reset       <= w_cmd.data[0];
                bp_cfg_reg_freeze_gp:      r_freeze      <= w_cmd.data[0];
                bp_cfg_reg_icache_mode_gp: r_icache_mode <= w_cmd.data[lce_mode_width_lp-1:0];
                bp_cfg_reg_dcache_mode_gp: r_dcache_mode <= w_cmd.data[lce_mode_width_lp-1:0];
                bp_cfg_reg_cce_mode_gp:    r_cce_mode    <= w_cmd.data[cce_mode_width_lp-1:0];
                bp_cfg_reg_npc_gp: begin
                  r_npc     <= w_cmd.data[vaddr_width_p-1:0];
                  r_npc_w_v <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        UCODE_RD: begin
          r_resp.data <= dword_width_p'(ucode_data_i);
          r_state     <= RESP;
        end
        RESP: begin
          if (io_resp_yumi_i) r_state <= READY;
        end
        default: r_state <= READY;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is held so nothing leaks
  // out during the reset cycle itself.
  assign io_cmd_ready_o = (r_state == READY) & ~reset_i;
  assign io_resp_v_o    = (r_state == RESP)  & ~reset_i;
  assign io_resp_o      = r_resp;

  assign reset_o       = r_reset;
  assign freeze_o      = r_freeze;
  assign icache_mode_o = r_icache_mode;
  assign dcache_mode_o = r_dcache_mode;
  assign cce_mode_o    = r_cce_mode;
  assign npc_o         = r_npc;
  assign npc_w_v_o     = r_npc_w_v;

  // Upper address bits, unused data bits and the high ucode offset bits
  // carry no meaning for this block.
  assign w_unused = ^{w_cmd.addr, w_cmd.data, w_ucode_off};

endmodule
